// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALUControl codes, LEGv8
// opcode constants, the buffered command type and the buffer state encoding.
package alu_pkg;

   // ALUControl codes consumed by the 64-bit datapath ALU
   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_ORR   = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;
   // NOR is reserved for the ALU but no opcode here ever selects it
   localparam logic [3:0] ALU_NOR   = 4'b1100;

   // LEGv8 opcode field values, instr[31:21]
   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   // CBZ only fixes the top eight bits; the low three are don't-care
   localparam logic [10:0] OP_CBZ      = 11'b10110100000;
   localparam logic [10:0] OP_CBZ_MASK = 11'b11111111000;

   // One buffered command: ALU control code plus the unmatched-opcode flag
   typedef struct packed {
      logic [3:0] ctrl;
      logic       illegal;
   } alu_cmd_t;

   // Occupancy of the two-slot skid buffer
   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_TWO   = 2'd2
   } buf_state_e;

   // Priority decode of an opcode; anything unmatched becomes AND with illegal set
   function automatic alu_cmd_t alu_decode(input logic [10:0] opcode);
      alu_cmd_t cmd;
      cmd.ctrl    = ALU_AND;
      cmd.illegal = 1'b0;
      if (opcode == OP_ADD)                              cmd.ctrl = ALU_ADD;
      else if (opcode == OP_SUB)                         cmd.ctrl = ALU_SUB;
      else if (opcode == OP_AND)                         cmd.ctrl = ALU_AND;
      else if (opcode == OP_ORR)                         cmd.ctrl = ALU_ORR;
      else if (opcode == OP_LDUR)                        cmd.ctrl = ALU_ADD;
      else if (opcode == OP_STUR)                        cmd.ctrl = ALU_ADD;
      else if ((opcode & OP_CBZ_MASK) == OP_CBZ)         cmd.ctrl = ALU_PASSB;
      else                                               cmd.illegal = 1'b1;
      return cmd;
   endfunction

endpackage

// File: rtl/alu_skid_buffer.sv
// Two-entry valid/ready skid buffer over alu_cmd_t. The main slot drives the
// outputs; the skid slot catches one extra command so that in_ready_o is a
// flop and never depends combinationally on out_ready_i.
module alu_skid_buffer
   import alu_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     in_valid_i,
   output logic     in_ready_o,
   input  alu_cmd_t in_cmd_i,
   output logic     out_valid_o,
   input  logic     out_ready_i,
   output alu_cmd_t out_cmd_o
);

   buf_state_e state_q, state_d;
   alu_cmd_t   main_q, main_d;
   alu_cmd_t   skid_q, skid_d;
   logic       inReady_q, inReady_d;
   logic       accept;
   logic       handshake;

   assign accept      = in_valid_i & inReady_q;
   assign handshake   = (state_q != BUF_EMPTY) & out_ready_i;
   assign in_ready_o  = inReady_q;
   assign out_valid_o = (state_q != BUF_EMPTY);
   assign out_cmd_o   = main_q;

   // Next-state and slot movement; in TWO the input side is closed so in_valid is ignored
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         BUF_EMPTY: begin
            if (accept) begin
               main_d  = in_cmd_i;
               state_d = BUF_ONE;
            end
         end
         BUF_ONE: begin
            if (accept && handshake) begin
               main_d = in_cmd_i;
            end else if (handshake) begin
               state_d = BUF_EMPTY;
            end else if (accept) begin
               skid_d  = in_cmd_i;
               state_d = BUF_TWO;
            end
         end
         BUF_TWO: begin
            if (handshake) begin
               main_d  = skid_q;
               skid_d  = '0;
               state_d = BUF_ONE;
            end
         end
         default: state_d = BUF_EMPTY;
      endcase
      inReady_d = (state_d != BUF_TWO);
   end

   // Register the buffer state, both slots and the registered ready flag
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= BUF_EMPTY;
         main_q    <= '0;
         skid_q    <= '0;
         inReady_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         main_q    <= main_d;
         skid_q    <= skid_d;
         inReady_q <= inReady_d;
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage ahead of the 64-bit ALU: decodes LEGv8 opcodes into ALUControl
// codes, buffers them in a two-entry skid buffer and counts issued commands.
// Build option: define ALU_ISSUE_ILLEGAL_EN to report unmatched opcodes on
// out_illegal; without it the illegal bit is held at zero.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [10:0]      in_opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_alu_control,
   output logic             out_illegal,
   output logic [CNT_W-1:0] issued_count
);

   alu_cmd_t         decCmd;
   alu_cmd_t         bufCmd;
   logic [CNT_W-1:0] count_q, count_d;
   logic             handshake;

   // Decode the incoming opcode; without the illegal feature the flag is forced
   // to zero so the stored bit is a constant and gets trimmed
   always_comb begin
      decCmd = alu_decode(in_opcode);
`ifdef ALU_ISSUE_ILLEGAL_EN
      decCmd.illegal = decCmd.illegal;
`else
      decCmd.illegal = 1'b0;
`endif
   end

   alu_skid_buffer u_buffer (
      .clk         (clk),
      .reset       (reset),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_cmd_i    (decCmd),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_cmd_o   (bufCmd)
   );

   assign out_alu_control = bufCmd.ctrl;
   assign out_illegal     = bufCmd.illegal;
   assign handshake       = out_valid & out_ready;
   assign issued_count    = count_q;

   // Saturating increment: the counter parks at all-ones
   always_comb begin
      count_d = count_q;
      if (handshake && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Issued-command counter; reset wins over a same-cycle handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: accepted opcodes are decoded by a
// reference table and queued, output handshakes pop and compare in order.
module tb_alu_issue_stage;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_CBZ  = 11'b10110100101;
   localparam logic [10:0] OP_BAD  = 11'b00000000000;

`ifdef ALU_ISSUE_ILLEGAL_EN
   localparam logic ILL_EXP = 1'b1;
`else
   localparam logic ILL_EXP = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [10:0] in_opcode;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_alu_control;
   logic        out_illegal;
   logic [15:0] issued_count;

   int          errors = 0;
   int          checks = 0;
   int          modelCount = 0;
   logic [4:0]  sbQ[$];

   alu_issue_stage #(.CNT_W(16)) dut (
      .clk             (clk),
      .reset           (reset),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_opcode       (in_opcode),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_alu_control (out_alu_control),
      .out_illegal     (out_illegal),
      .issued_count    (issued_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference decode, {ctrl, illegal}
   function automatic logic [4:0] expectedCmd(input logic [10:0] op);
      casez (op)
         11'b10001011000: return 5'b0010_0;
         11'b11001011000: return 5'b0110_0;
         11'b10001010000: return 5'b0000_0;
         11'b10101010000: return 5'b0001_0;
         11'b11111000010: return 5'b0010_0;
         11'b11111000000: return 5'b0010_0;
         11'b10110100???: return 5'b0111_0;
         default:         return {4'b0000, ILL_EXP};
      endcase
   endfunction

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Drive one cycle of inputs, return just after the active edge
   task automatic applyStimulus(input logic v, input logic [10:0] op, input logic r);
      in_valid  = v;
      in_opcode = op;
      out_ready = r;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: sampled on the falling edge, away from the active edge
   always @(negedge clk) begin
      logic [4:0] exp;
      checkOutput("count", {16'h0, issued_count}, (modelCount > 65535) ? 32'd65535 : modelCount);
      if (reset) begin
         sbQ.delete();
         modelCount = 0;
      end else begin
         if (out_valid && out_ready) begin
            if (sbQ.size() == 0) begin
               checkOutput("sbUnderflow", 32'd1, 32'd0);
            end else begin
               exp = sbQ.pop_front();
               checkOutput("sbCtrl", {28'h0, out_alu_control}, {28'h0, exp[4:1]});
               checkOutput("sbIllegal", {31'h0, out_illegal}, {31'h0, exp[0]});
            end
            modelCount++;
         end
         if (in_valid && in_ready) sbQ.push_back(expectedCmd(in_opcode));
      end
   end

   initial begin
      logic [10:0] stream[7];
      logic [3:0]  codes[7];
      int          waitCycles;
      stream = '{OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR, OP_CBZ};
      codes  = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0010, 4'b0010, 4'b0111};

      reset = 1'b1;
      in_valid = 1'b0;
      in_opcode = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("rstOutValid", {31'h0, out_valid}, 32'd0);
      checkOutput("rstInReady", {31'h0, in_ready}, 32'd1);
      checkOutput("rstCtrl", {28'h0, out_alu_control}, 32'd0);
      checkOutput("rstIllegal", {31'h0, out_illegal}, 32'd0);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("idleOutValid", {31'h0, out_valid}, 32'd0);
      checkOutput("idleCount", {16'h0, issued_count}, 32'd0);

      // Back-to-back stream, each result visible one cycle after accept
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, stream[i], 1'b1);
         checkOutput("streamValid", {31'h0, out_valid}, 32'd1);
         checkOutput("streamCtrl", {28'h0, out_alu_control}, {28'h0, codes[i]});
      end
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("streamCount", {16'h0, issued_count}, 32'd7);
      checkOutput("streamDrained", {31'h0, out_valid}, 32'd0);

      // Stall: SUB to main, ORR to skid, ADD held off
      applyStimulus(1'b1, OP_SUB, 1'b0);
      checkOutput("stallInReady1", {31'h0, in_ready}, 32'd1);
      applyStimulus(1'b1, OP_ORR, 1'b0);
      checkOutput("stallInReady2", {31'h0, in_ready}, 32'd0);
      applyStimulus(1'b1, OP_ADD, 1'b0);
      applyStimulus(1'b1, OP_ADD, 1'b0);
      checkOutput("stallHeldCtrl", {28'h0, out_alu_control}, 32'b0110);
      checkOutput("stallHeldReady", {31'h0, in_ready}, 32'd0);
      // Release; keep ADD offered until the stage takes it
      waitCycles = 0;
      while (!in_ready && waitCycles < 10) begin
         applyStimulus(1'b1, OP_ADD, 1'b1);
         waitCycles++;
      end
      checkOutput("releaseTimeout", {31'h0, in_ready}, 32'd1);
      applyStimulus(1'b1, OP_ADD, 1'b1);
      repeat (3) applyStimulus(1'b0, '0, 1'b1);
      checkOutput("releaseDrained", {31'h0, out_valid}, 32'd0);
      checkOutput("releaseQueue", sbQ.size(), 32'd0);

      // Unmatched opcode
      applyStimulus(1'b1, OP_BAD, 1'b1);
      checkOutput("illegalCtrl", {28'h0, out_alu_control}, 32'd0);
      checkOutput("illegalFlag", {31'h0, out_illegal}, {31'h0, ILL_EXP});
      applyStimulus(1'b0, '0, 1'b1);

      // Fill to TWO then reset for one cycle with out_ready high
      applyStimulus(1'b1, OP_SUB, 1'b0);
      applyStimulus(1'b1, OP_ORR, 1'b0);
      checkOutput("preRstTwo", {31'h0, in_ready}, 32'd0);
      reset = 1'b1;
      applyStimulus(1'b0, '0, 1'b1);
      reset = 1'b0;
      checkOutput("midRstOutValid", {31'h0, out_valid}, 32'd0);
      checkOutput("midRstInReady", {31'h0, in_ready}, 32'd1);
      checkOutput("midRstCount", {16'h0, issued_count}, 32'd0);
      repeat (3) begin
         applyStimulus(1'b0, '0, 1'b1);
         checkOutput("noStaleEntry", {31'h0, out_valid}, 32'd0);
      end

      // Saturation: stream until the counter is all-ones, then keep issuing
      waitCycles = 0;
      while (issued_count != 16'hFFFF && waitCycles < 70000) begin
         applyStimulus(1'b1, OP_ADD, 1'b1);
         waitCycles++;
      end
      checkOutput("satReached", {16'h0, issued_count}, 32'hFFFF);
      repeat (3) applyStimulus(1'b1, OP_AND, 1'b1);
      checkOutput("satHandshake", {31'h0, out_valid}, 32'd1);
      checkOutput("satHold", {16'h0, issued_count}, 32'hFFFF);
      repeat (3) applyStimulus(1'b0, '0, 1'b1);
      checkOutput("satHoldIdle", {16'h0, issued_count}, 32'hFFFF);
      checkOutput("finalQueue", sbQ.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
